// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SPI-mode SD card init sequencer (power-up clocks, CMD0, CMD8, CMD55/ACMD41 loop)
// with bit-serial framing, R1/R7 capture and coded error reporting.
module sd_init_ctrl #(
    parameter int CLK_DIV        = 64,
    parameter int RESP_TIMEOUT   = 64,
    parameter int ACMD41_RETRIES = 1000,
    parameter int DUMMY_CLKS     = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       sd_sclk,
    output logic       sd_cs_n,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] err_code,
    output logic [7:0] last_r1
);
    localparam int MAXB = (DUMMY_CLKS > RESP_TIMEOUT) ? ((DUMMY_CLKS > 48) ? DUMMY_CLKS : 48)
                                                      : ((RESP_TIMEOUT > 48) ? RESP_TIMEOUT : 48);
    localparam int BW = $clog2(MAXB + 1);
    localparam int DW = $clog2(CLK_DIV);
    localparam int RW = $clog2(ACMD41_RETRIES + 1);
    localparam logic [1:0] C0 = 2'd0, C8 = 2'd1, C55 = 2'd2, C41 = 2'd3;

    typedef enum logic [2:0] {IDLE, POWERUP, SEND, WAIT_R1, R1, R7, GAP, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div;
    logic [BW-1:0] bits;
    logic [RW-1:0] retry;
    logic [47:0]   frame;
    logic [11:0]   rx;
    logic [1:0]    cmd, cmd_nxt;
    logic [2:0]    code_nxt;
    logic          active, tick, rise, fall, more;

    assign active = state inside {POWERUP, SEND, WAIT_R1, R1, R7, GAP};
    assign tick   = active && div == DW'(CLK_DIV - 1);
    assign rise   = tick && !sd_sclk;
    assign fall   = tick && sd_sclk;
    assign more   = 32'(retry) + 1 < ACMD41_RETRIES;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // All transitions happen on SCLK falling ticks, so MOSI changes only while SCLK is low
    // and every fall is preceded by a fresh MISO sample taken on the rise.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        code_nxt  = 3'd0;
        case (state)
            IDLE:    if (start) begin state_nxt = POWERUP; cmd_nxt = C0; end
            POWERUP: if (fall && bits == BW'(DUMMY_CLKS)) state_nxt = SEND;
            SEND:    if (fall && bits == BW'(48)) state_nxt = WAIT_R1;
            WAIT_R1: if (fall && (!rx[0] || bits == BW'(RESP_TIMEOUT))) begin
                state_nxt = rx[0] ? DONE : R1;
                code_nxt  = 3'd1;
            end
            R1: if (fall && bits == BW'(7)) begin
                case (cmd)
                    C0:  begin state_nxt = (rx[7:0] == 8'h01) ? GAP : DONE; cmd_nxt = C8; code_nxt = 3'd2; end
                    C8:  begin state_nxt = (rx[7:0] == 8'h01) ? R7 : DONE; code_nxt = 3'd3; end
                    C55: begin state_nxt = GAP; cmd_nxt = C41; end
                    default: begin
                        state_nxt = (rx[7:0] == 8'h01 && more) ? GAP : DONE;
                        cmd_nxt   = C55;
                        code_nxt  = (rx[7:0] == 8'h00) ? 3'd0 : 3'd4;
                    end
                endcase
            end
            R7: if (fall && bits == BW'(32)) begin
                state_nxt = (rx == 12'h1AA) ? GAP : DONE;
                cmd_nxt   = C55;
                code_nxt  = 3'd3;
            end
            GAP:  if (fall && bits == BW'(8)) state_nxt = SEND;
            DONE: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = active;
        done    = state == DONE;
        sd_cs_n = !(state inside {SEND, WAIT_R1, R1, R7, GAP});
        sd_mosi = (state == SEND) ? frame[47] : 1'b1;
        error   = |err_code;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div      <= '0;
            sd_sclk  <= 1'b0;
            bits     <= '0;
            retry    <= '0;
            frame    <= '1;
            rx       <= '1;
            cmd      <= C0;
            err_code <= 3'd0;
            last_r1  <= 8'hFF;
        end else begin
            div <= (!active || tick) ? '0 : div + 1'b1;
            if (tick) sd_sclk <= ~sd_sclk;
            bits <= (state_nxt != state) ? '0 : rise ? bits + 1'b1 : bits;
            if (rise) rx <= {rx[10:0], sd_miso};
            cmd <= cmd_nxt;
            if (state_nxt == SEND && state != SEND)
                frame <= (cmd == C0) ? 48'h40_0000_0000_95 : (cmd == C8) ? 48'h48_0000_01AA_87 :
                         (cmd == C55) ? 48'h77_0000_0000_65 : 48'h69_4000_0000_77;
            else if (state == SEND && fall)
                frame <= {frame[46:0], 1'b1};
            if (state == R1 && state_nxt != R1) begin
                last_r1 <= rx[7:0];
                if (cmd == C41 && rx[7:0] == 8'h01) retry <= retry + 1'b1;
            end
            if (state_nxt == DONE && state != DONE) err_code <= code_nxt;
            if (state == IDLE && start) begin
                retry    <= '0;
                err_code <= 3'd0;
                last_r1  <= 8'hFF;
            end
        end
endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: scoreboard bench for sd_init_ctrl driven by a behavioural SPI SD card with
// randomized response latency and response values.
module tb_sd_init_ctrl;
    localparam int CLK_DIV = 3, RESP_TIMEOUT = 64, RETRIES = 4, DUMMY = 80;
    localparam logic [47:0] F0 = 48'h40_0000_0000_95, F8 = 48'h48_0000_01AA_87;
    localparam logic [47:0] F55 = 48'h77_0000_0000_65, F41 = 48'h69_4000_0000_77;

    logic clk = 0, rst_n = 0, start = 0, sd_miso = 1;
    logic sd_sclk, sd_cs_n, sd_mosi, busy, done, error;
    logic [2:0] err_code;
    logic [7:0] last_r1;
    int vectors = 0, fails = 0, dones = 0;

    typedef struct {
        logic [2:0] code;
        logic [7:0] r1;
        int         pairs;
        int         base;
    } exp_t;
    exp_t        exp_q[$];
    logic [47:0] frame_q[$];

    bit          cfg_stuck;
    logic [7:0]  cfg_c0, cfg_c8;
    logic [11:0] cfg_r7;
    int          cfg_ones;

    logic [47:0] csr = '1;
    bit          rx_q[$];
    bit          seen_low = 1;
    int          dummy = 0, low_rises = 0, ncr_total = 0, run_a41 = 0, run_frames = 0;

    sd_init_ctrl #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .ACMD41_RETRIES(RETRIES),
                   .DUMMY_CLKS(DUMMY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sd_sclk(sd_sclk), .sd_cs_n(sd_cs_n),
        .sd_mosi(sd_mosi), .sd_miso(sd_miso), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .last_r1(last_r1)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint want);
        vectors++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endfunction

    // Card: samples MOSI on SCLK rise, answers each complete frame with Ncr idle bits,
    // R1 and (for an accepted CMD8) R7, driving MISO on SCLK fall.
    always @(sd_sclk) begin : card
        logic [7:0]  r1;
        logic [31:0] r7w;
        logic [47:0] want;
        logic [5:0]  idx;
        int          ncr;
        if (sd_sclk) begin
            if (sd_cs_n) begin
                if (seen_low) begin
                    seen_low = 0; dummy = 0; low_rises = 0; ncr_total = 0; run_a41 = 0; run_frames = 0;
                end
                if (sd_mosi) dummy++;
                csr = '1;
                rx_q.delete();
            end else begin
                seen_low = 1;
                low_rises++;
                csr = {csr[46:0], sd_mosi};
                if (csr[47:46] == 2'b01 && csr[0]) begin
                    run_frames++;
                    want = (frame_q.size() > 0) ? frame_q.pop_front() : 48'h0;
                    check("frame", csr, want);
                    idx = csr[45:40];
                    r1 = (idx == 0) ? cfg_c0 : (idx == 8) ? cfg_c8 :
                         (idx == 55) ? 8'($urandom_range(0, 1)) : (run_a41 < cfg_ones) ? 8'h01 : 8'h00;
                    if (idx == 41) run_a41++;
                    if (!cfg_stuck) begin
                        ncr = $urandom_range(0, 8);
                        ncr_total += ncr;
                        repeat (ncr) rx_q.push_back(1'b1);
                        for (int i = 7; i >= 0; i--) rx_q.push_back(r1[i]);
                        r7w = {20'h0, cfg_r7};
                        if (idx == 8 && r1 == 8'h01)
                            for (int i = 31; i >= 0; i--) rx_q.push_back(r7w[i]);
                    end
                    csr = '1;
                end
            end
        end else
            sd_miso = (!sd_cs_n && rx_q.size() > 0) ? rx_q.pop_front() : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            dones++;
            if (exp_q.size() == 0) check("done_unexpected", done, 0);
            else begin
                e = exp_q.pop_front();
                check("err_code", err_code, e.code);
                check("error", error, e.code != 0);
                check("last_r1", last_r1, e.r1);
                check("cs_n_done", sd_cs_n, 1);
                check("sclk_done", sd_sclk, 0);
                check("busy_done", busy, 0);
                check("pairs", run_a41, e.pairs);
                check("dummy_clks", dummy, DUMMY);
                check("bit_times", low_rises, e.base + ncr_total);
                check("frames_left", frame_q.size(), 0);
            end
        end
    end

    // Reference outcome from the command rules; each command costs 48 frame bits plus 8 R1 bits
    // (+Ncr), an accepted CMD8 adds 32 R7 bits and every non-final response adds 8 GAP bits.
    task automatic predict(input bit stuck, input logic [7:0] c0, c8, input logic [11:0] r7,
                           input int ones, output exp_t e);
        int n;
        e.pairs = 0;
        frame_q.push_back(F0);
        if (stuck) begin
            e.code = 1; e.r1 = 8'hFF; e.base = 48 + RESP_TIMEOUT;
        end else if (c0 != 8'h01) begin
            e.code = 2; e.r1 = c0; e.base = 56;
        end else if (c8 != 8'h01) begin
            e.code = 3; e.r1 = c8; e.base = 2 * 56 + 8; frame_q.push_back(F8);
        end else if (r7 != 12'h1AA) begin
            e.code = 3; e.r1 = 8'h01; e.base = 2 * 56 + 32 + 8; frame_q.push_back(F8);
        end else begin
            e.pairs = (ones < RETRIES) ? ones + 1 : RETRIES;
            e.code  = (ones < RETRIES) ? 3'd0 : 3'd4;
            e.r1    = (ones < RETRIES) ? 8'h00 : 8'h01;
            n = 2 + 2 * e.pairs;
            e.base = 56 * n + 32 + 8 * (n - 1);
            frame_q.push_back(F8);
            repeat (e.pairs) begin frame_q.push_back(F55); frame_q.push_back(F41); end
        end
    endtask

    task automatic configure(input bit stuck, input logic [7:0] c0, c8, input logic [11:0] r7, input int ones);
        cfg_stuck = stuck; cfg_c0 = c0; cfg_c8 = c8; cfg_r7 = r7; cfg_ones = ones;
    endtask

    task automatic run(input bit stuck, input logic [7:0] c0, c8, input logic [11:0] r7,
                       input int ones, input bit poke);
        exp_t e;
        int n, k;
        configure(stuck, c0, c8, r7, ones);
        predict(stuck, c0, c8, r7, ones, e);
        exp_q.push_back(e);
        n = dones;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("busy_rise", busy, 1);
        k = 1;
        while (!sd_sclk && k < 200) begin @(negedge clk); k++; end
        check("first_sclk", k - 1, CLK_DIV);
        if (poke) begin
            repeat ($urandom_range(10, 500)) @(negedge clk);
            start = 1; @(negedge clk); start = 0;
        end
        k = 0;
        while (dones == n && k < 30000) begin @(negedge clk); k++; end
        check("run_done", dones - n, 1);
    endtask

    task automatic abort_cmd8();
        int k;
        configure(0, 8'h01, 8'h01, 12'h1AA, 2);
        frame_q.push_back(F0);
        frame_q.push_back(F8);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        k = 0;
        while (sd_cs_n && k < 20000) begin @(negedge clk); k++; end
        while (!(run_frames == 1 && !sd_cs_n && !sd_mosi) && k < 20000) begin @(negedge clk); k++; end
        check("abort_reached", k < 20000, 1);
        repeat ($urandom_range(1, 200)) @(negedge clk);
        @(posedge clk); #1 rst_n = 0;
        #1;
        check("abort_cs_n", sd_cs_n, 1);
        check("abort_sclk", sd_sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_mosi", sd_mosi, 1);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk);
        frame_q.delete();
        rst_n = 1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sclk", sd_sclk, 0);
        check("rst_cs_n", sd_cs_n, 1);
        check("rst_mosi", sd_mosi, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_last_r1", last_r1, 8'hFF);
        rst_n = 1;
        run(0, 8'h01, 8'h01, 12'h1AA, 2, 0);
        run(1, 8'h01, 8'h01, 12'h1AA, 2, 0);
        run(0, 8'h05, 8'h01, 12'h1AA, 2, 0);
        run(0, 8'h01, 8'h05, 12'h1AA, 2, 0);
        run(0, 8'h01, 8'h01, 12'h1AB, 2, 0);
        run(0, 8'h01, 8'h01, 12'h1AA, 1000, 0);
        run(0, 8'h01, 8'h01, 12'h1AA, RETRIES - 1, 0);
        abort_cmd8();
        run(0, 8'h01, 8'h01, 12'h1AA, 2, 0);
        repeat (4)
            run($urandom_range(0, 5) == 0, 8'h01, ($urandom_range(0, 3) == 0) ? 8'h05 : 8'h01,
                ($urandom_range(0, 3) == 0) ? 12'h1AB : 12'h1AA, $urandom_range(0, 5), 1);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/sd_init_ctrl.md
# sd_init_ctrl

SPI-mode SD card initialisation sequencer. On `start`, drives the SD SPI pins through power-up clocking, CMD0, CMD8, and the CMD55/ACMD41 loop, then reports ready or a coded error. It sits between the top-level game/asset loader and the card pins, and owns the bit-serial command framing and R1/R7 response capture that the block-read path needs before it may run.

## Interface
- CLK_DIV, 64: `clk` cycles per SCLK half-period (≥2).
- RESP_TIMEOUT, 64: max SCLK bit-times waiting for an R1 start bit.
- ACMD41_RETRIES, 1000: max CMD55/ACMD41 pairs before giving up.
- DUMMY_CLKS, 80: power-up SCLK cycles with CS high.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- sd_sclk  out  1  SPI clock, mode 0 (idles low)
- sd_cs_n  out  1  card select, active low
- sd_mosi  out  1  command data, MSB first
- sd_miso  in  1  card response data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of sequence (success or error)
- error  out  1  valid with done; held until next accepted start
- err_code  out  3  0 ok, 1 response timeout, 2 bad CMD0 R1, 3 bad CMD8 R1/R7, 4 ACMD41 retries exhausted
- last_r1  out  8  most recent R1 byte captured

## Operation
- Bit tick: internal counter toggles SCLK every CLK_DIV `clk` cycles. MOSI updates on SCLK falling edge (or state entry while SCLK low). MISO sampled on SCLK rising edge.
- States: IDLE → POWERUP → SEND(cmd) → WAIT_R1 → [READ_R7] → GAP → next cmd … → DONE → IDLE.
- POWERUP: cs_n=1, mosi=1, exactly DUMMY_CLKS SCLK rising edges.
- SEND: cs_n=0. Shifts 48-bit frame MSB first. Frames:
  - CMD0 0x40_00000000_95
  - CMD8 0x48_000001AA_87
  - CMD55 0x77_00000000_65
  - ACMD41 0x69_40000000_77
- WAIT_R1: mosi=1. Samples until a 0 bit is seen. That bit is R1 bit 7; 7 more bits complete R1 into last_r1. If no 0 bit within RESP_TIMEOUT samples, go to DONE with err 1.
- Checks:
  - CMD0: R1 must be 0x01, else err 2.
  - CMD8: R1 must be 0x01, then READ_R7 captures 32 bits; bits[11:0] must be 0x1AA. Any mismatch (including R1 0x05) gives err 3.
  - CMD55: R1 bit 7 clear is accepted (0x00 or 0x01), else err 3 is not used; a timeout gives err 1.
  - ACMD41: 0x00 → success. 0x01 → retry counter +1; if retry counter < ACMD41_RETRIES, issue CMD55 again, else err 4. Any other value → err 4.
- GAP: 8 SCLK cycles, mosi=1, cs_n=0, between every response and the next command.
- DONE: cs_n=1. One `clk` in DONE pulses done, sets error/err_code, then goes to IDLE.
- SCLK idles low in IDLE and DONE. No SCLK edges in IDLE.

## Timing
- Reset values (asynchronous): sd_sclk=0, sd_cs_n=1, sd_mosi=1, busy=0, done=0, error=0, err_code=0, last_r1=0xFF, all counters 0, state IDLE.
- busy rises the `clk` after start is sampled high in IDLE. busy falls in the same cycle done pulses.
- start while busy: ignored. start held high in IDLE after done: restarts the sequence, which is legal.
- First SCLK rising edge occurs CLK_DIV cycles after busy rises.
- Bit-times per command with an immediate R1: 48 frame bits, then 1–RESP_TIMEOUT bits to the start bit, +7 R1 bits, +32 bits (CMD8 only), +8 GAP bits.
- R1 start bit sampled in the first WAIT_R1 bit-time is accepted (Ncr=0 allowed).
- Retry counter width covers ACMD41_RETRIES. It is cleared on start.
- rst_n asserted mid-frame: outputs go to reset values immediately. No partial done pulse is produced.

## Test plan
- Cooperative card model (CMD0→0x01, CMD8→0x01+0x000001AA, ACMD41→0x01 twice then 0x00) → done=1, error=0, err_code=0, last_r1=0x00, exactly three CMD55/ACMD41 pairs seen, 80 SCLK edges with cs_n=1 before the first CMD0 bit.
- Frame check: capture MOSI on SCLK rise → byte streams 40 00 00 00 00 95, 48 00 00 01 AA 87, 77 00 00 00 00 65, 69 40 00 00 00 77.
- MISO stuck at 1 → after CMD0 + 64 bit-times, done with error=1, err_code=1, last_r1=0xFF, cs_n=1.
- CMD8 returns R1=0x05 → err_code=3, last_r1=0x05. Separate run with R7 check pattern 0x1AB → err_code=3.
- ACMD41 always 0x01 with ACMD41_RETRIES=4 → exactly 4 pairs issued, then err_code=4.
- rst_n pulsed low during CMD8 transmission → sd_cs_n=1, sd_sclk=0, busy=0 within the same cycle. A new start afterwards completes successfully.
